// File: rtl/bnn_pkg.sv
// Shared types and helpers for the sequential binary dot-product unit.
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int DEF_LEN_DEFAULT = 9;

    // Number of datapath words needed to cover len bits.
    function automatic int unsigned word_count(input int unsigned len, input int unsigned xlen);
        return (len + xlen - 1) / xlen;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Masked population count over one datapath word.
module bnn_popcount #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]        data,
    input  logic [XLEN-1:0]        mask,
    output logic [$clog2(XLEN):0]  count
);

    localparam int CW = $clog2(XLEN) + 1;

    always_comb begin
        count = '0;
        for (int i = 0; i < XLEN; i++)
            count = count + CW'(data[i] & mask[i]);
    end

endmodule

// File: rtl/bnn_seq_dot.sv
// Multi-beat XNOR/popcount dot product with optional threshold activation.
module bnn_seq_dot
    import bnn_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LEN_W   = 16,
    parameter int DEF_LEN = DEF_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_len_we,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_thr_we,
    input  logic [XLEN-1:0]  cfg_thr,
    input  logic             start,
    input  logic             en_threshold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int BW = LEN_W + CW;

    state_t state, state_nx;

    logic [LEN_W-1:0]        len_reg, op_len, wcnt, sel_len;
    logic [XLEN-1:0]         thr_reg, op_thr, sel_thr, result_q, res_d, sum_x, xnor_w, mask;
    logic                    op_mode, sel_mode, act;
    logic [LEN_W:0]          acc, acc_nx;
    logic [CW-1:0]           pop;
    logic [BW-1:0]           base;
    logic signed [LEN_W+1:0] sum_n;
    logic                    start_go, beat, last_beat, load;

    assign start_go  = (state == IDLE) && start;
    assign beat      = (state == ACCUM) && in_valid;
    assign last_beat = (wcnt == LEN_W'(word_count(32'(op_len), unsigned'(XLEN)) - 1));
    assign load      = (start_go && (len_reg == '0)) || (beat && last_beat);

    // Bit i of beat k counts only while k*XLEN+i is inside the vector.
    assign xnor_w = ~(in_a ^ in_w);
    assign base   = BW'(wcnt) * BW'(XLEN);
    for (genvar i = 0; i < XLEN; i++) begin : g_mask
        assign mask[i] = (base + BW'(i)) < BW'(op_len);
    end

    bnn_popcount #(.XLEN(XLEN)) u_pop (
        .data  (xnor_w),
        .mask  (mask),
        .count (pop)
    );

    // A zero-length start finishes in the same cycle, before op_* are loaded.
    assign sel_len  = start_go ? len_reg      : op_len;
    assign sel_thr  = start_go ? thr_reg      : op_thr;
    assign sel_mode = start_go ? en_threshold : op_mode;
    assign acc_nx   = start_go ? '0 : (beat ? acc + (LEN_W+1)'(pop) : acc);
    assign sum_n    = $signed({acc_nx, 1'b0}) - $signed({2'b00, sel_len});
    assign sum_x    = {{(XLEN-LEN_W-2){sum_n[LEN_W+1]}}, sum_n};
    assign act      = $signed(sum_x) >= $signed(sel_thr);
    assign res_d    = sel_mode ? {{(XLEN-1){1'b0}}, act} : sum_x;
    assign result   = result_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nx = (len_reg == '0) ? DONE : ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (beat && last_beat) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg  <= LEN_W'(DEF_LEN);
            thr_reg  <= '0;
            op_len   <= '0;
            op_thr   <= '0;
            op_mode  <= 1'b0;
            acc      <= '0;
            wcnt     <= '0;
            result_q <= '0;
        end else begin
            if (state == IDLE) begin
                if (cfg_len_we) len_reg <= cfg_len;
                if (cfg_thr_we) thr_reg <= cfg_thr;
            end
            if (start_go) begin
                op_len  <= len_reg;
                op_thr  <= thr_reg;
                op_mode <= en_threshold;
                wcnt    <= '0;
            end else if (beat) begin
                wcnt <= wcnt + 1'b1;
            end
            acc <= acc_nx;
            if (load) result_q <= res_d;
        end
    end

endmodule

// File: tb/tb_bnn_seq_dot.sv
// Directed bench for bnn_seq_dot with hand-computed expected results.
module tb_bnn_seq_dot;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_len_we = 1'b0;
    logic [15:0] cfg_len = '0;
    logic        cfg_thr_we = 1'b0;
    logic [31:0] cfg_thr = '0;
    logic        start = 1'b0;
    logic        en_threshold = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_w = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bnn_seq_dot dut (
        .clk(clk), .reset(reset),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .cfg_thr_we(cfg_thr_we), .cfg_thr(cfg_thr),
        .start(start), .en_threshold(en_threshold),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input logic [15:0] v);
        cfg_len_we = 1'b1; cfg_len = v; tick; cfg_len_we = 1'b0;
    endtask

    task automatic set_thr(input logic [31:0] v);
        cfg_thr_we = 1'b1; cfg_thr = v; tick; cfg_thr_we = 1'b0;
    endtask

    task automatic begin_op(input logic mode);
        start = 1'b1; en_threshold = mode; tick; start = 1'b0;
    endtask

    task automatic beats(input int nb, input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < nb; k++) begin
            int t = 0;
            in_valid = 1'b1; in_a = a; in_w = w;
            while (!in_ready && t < 10) begin tick; t++; end
            chk("in_ready_beat", in_ready, 1'b1);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, result, exp);
        out_ready = 1'b1; tick; out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        tick; tick;
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_len", dut.len_reg, 32'd9);

        // default length 9: all-equal operands give +9
        begin_op(1'b0); beats(1, 32'h0, 32'h0); finish("len9", 32'd9);
        // upper 23 bits disagree but are masked off
        begin_op(1'b0); beats(1, 32'h0, 32'hFFFF_FE00); finish("len9_mask", 32'd9);

        set_len(16'd70);
        begin_op(1'b0); beats(3, 32'hA5A5_A5A5, 32'hA5A5_A5A5); finish("len70_sum", 32'd70);
        set_thr(32'd70);
        begin_op(1'b1); beats(3, 32'hA5A5_A5A5, 32'hA5A5_A5A5); finish("len70_thr70", 32'd1);
        set_thr(32'd71);
        begin_op(1'b1); beats(3, 32'hA5A5_A5A5, 32'hA5A5_A5A5); finish("len70_thr71", 32'd0);

        set_len(16'd64);
        begin_op(1'b0); beats(2, 32'h0, 32'hFFFF_FFFF); finish("len64_neg", 32'hFFFF_FFC0);
        set_thr(32'hFFFF_FFC0);
        begin_op(1'b1); beats(2, 32'h0, 32'hFFFF_FFFF); finish("len64_thr", 32'd1);

        // backpressure: result held, start and config write ignored in DONE
        begin_op(1'b0); beats(2, 32'h0, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin start = 1'b1; cfg_len_we = 1'b1; cfg_len = 16'd5; end
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_result", result, 32'hFFFF_FFC0);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            tick;
            start = 1'b0; cfg_len_we = 1'b0;
        end
        chk("bp_len_kept", dut.len_reg, 32'd64);
        out_ready = 1'b1; tick; out_ready = 1'b0;
        chk("bp_release", out_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);

        // zero length: done the cycle after start, no beats taken
        set_len(16'd0);
        set_thr(32'd0);
        begin_op(1'b1);
        chk("len0_in_ready", in_ready, 1'b0);
        finish("len0_thr0", 32'd1);
        set_thr(32'd1);
        begin_op(1'b1); finish("len0_thr1", 32'd0);

        // reset mid-operation discards everything
        set_len(16'd70);
        begin_op(1'b0); beats(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        reset = 1'b1; tick; reset = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_len", dut.len_reg, 32'd9);
        begin_op(1'b0); beats(1, 32'h0, 32'h0); finish("post_rst", 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_seq_dot.md
Name: bnn_seq_dot

Overview:
Multi-cycle binary dot-product unit that generalises the single-word XNOR/popcount/threshold path to vectors longer than one datapath word. Operands stream in as XLEN-bit words over a valid/ready handshake. Popcounts are accumulated across beats with masking on the final partial word. One signed bipolar sum, or a thresholded 0/1 activation, is returned over a valid/ready output. The block sits beside the ALU as a BNN co-processor; vector length and threshold are held in configuration registers.

Parameters:
XLEN, 32, datapath word width in bits (operands and result)
LEN_W, 16, width of the vector-length register in bits; maximum vector length is 2^LEN_W-1
DEF_LEN, 9, vector length loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_len_we  in  1  write enable for the vector-length register
cfg_len  in  LEN_W  new vector length in bits
cfg_thr_we  in  1  write enable for the threshold register
cfg_thr  in  XLEN  new signed activation threshold
start  in  1  begin a new dot product
en_threshold  in  1  output mode: 1 = activation, 0 = signed sum; sampled at start
in_valid  in  1  operand beat valid
in_ready  out  1  unit accepts an operand beat
in_a  in  XLEN  activation word
in_w  in  XLEN  weight word
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  XLEN  signed sum (sign-extended) or activation (0/1)
busy  out  1  high whenever the state is not IDLE

Behaviour:
- One clock domain (clk). reset is synchronous and active-high. On reset: state=IDLE, len_reg=DEF_LEN, thr_reg=0, accumulator=0, word counter=0, in_ready=0, out_valid=0, result=0, busy=0.
- Config writes take effect only in IDLE; in any other state they are ignored. When start and a config write occur in the same IDLE cycle, start snapshots the pre-write register values and the write updates the register for the next operation.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: start=1 snapshots len_reg into op_len, thr_reg into op_thr and en_threshold into op_mode. It clears the accumulator and word counter. If op_len=0, go to DONE; otherwise go to ACCUM.
- ACCUM: in_ready=1. A beat is accepted when in_valid&&in_ready. Per accepted beat k (0-based):
  - xnor = ~(in_a ^ in_w)
  - bit i is counted only if k*XLEN+i < op_len
  - the accumulator adds the popcount in the same cycle
  - k increments
- Leaving ACCUM: on acceptance of beat k = ceil(op_len/XLEN)-1, go to DONE.
- DONE:
  - out_valid=1; result is registered on entry and held stable while out_valid && !out_ready.
  - out_valid&&out_ready returns the FSM to IDLE, with out_valid=0 the next cycle.
  - start is ignored in ACCUM and DONE.
- Latency: out_valid rises on the cycle after the last beat is accepted, or the cycle after start when op_len=0.
- Arithmetic:
  - The accumulator is LEN_W+1 bits and cannot overflow.
  - sum = 2*acc - op_len, computed signed at LEN_W+2 bits and sign-extended to XLEN.
  - activation = (sum >= op_thr), signed compare at XLEN.
  - result = op_mode ? {0..,activation} : sum.
- in_a and in_w are don't-care when not accepted. Masked bits never contribute, whatever their value.
- Reset mid-operation: immediate return to the reset state. The partial accumulation is discarded and no out_valid is produced.

Decomposition:
- Shared package bnn_pkg holds:
  - the state enum (IDLE, ACCUM, DONE)
  - DEF_LEN default
  - a function for ceil(len/XLEN) word count
- One sub-module, bnn_popcount: combinational, XLEN-bit data plus XLEN-bit mask in, $clog2(XLEN)+1-bit count out.
- The mask is generated in bnn_seq_dot from the word counter and op_len.

Test Plan:
1. Reset, then start with en_threshold=0 and one beat in_a=in_w=0 (default len 9, only 9 bits counted) -> out_valid next cycle, result=9.
2. cfg_len=70, three beats with in_a=in_w=0xA5A5A5A5, en_threshold=0 -> result=70. Repeat with en_threshold=1 and cfg_thr=70 -> 1; with cfg_thr=71 -> 0.
3. cfg_len=64, two beats with in_a=0x0, in_w=0xFFFFFFFF -> result=0xFFFFFFC0 (-64). With en_threshold=1, cfg_thr=0xFFFFFFC0 -> 1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse start plus cfg_len_we=5 -> result stable, in_ready=0, busy=1, len_reg unchanged. Then out_ready=1 -> IDLE the next cycle.
5. cfg_len=0, start with en_threshold=1 and thr=0 -> out_valid the cycle after start, result=1, no beats accepted. With thr=1 -> result=0.
6. cfg_len=70, accept 1 beat, assert reset -> next cycle: busy=0, in_ready=0, out_valid=0, len_reg=9. A following len-9 run gives result=9 (no residue).
